// File: rtl/div_ctrl_if.sv
// Purpose: groups the execute-stage divide request, cancel, stall and result signals.
// Ports: master (pipeline) drives start/signed_div/a/b/annul; slave (divider) drives
//        stall_div/ready/result back to the pipeline and hazard unit.
interface div_ctrl_if;
  logic        start;
  logic        signed_div;
  logic [31:0] a;
  logic [31:0] b;
  logic        annul;
  logic        stall_div;
  logic        ready;
  logic [63:0] result;

  modport master (
    output start, signed_div, a, b, annul,
    input  stall_div, ready, result
  );

  modport slave (
    input  start, signed_div, a, b, annul,
    output stall_div, ready, result
  );
endinterface

// File: rtl/div_ctrl.sv
// Purpose: multi-cycle restoring radix-2 div/divu unit; 33 cycles start->ready, 2 for b==0.
// Ports: clk, rst (sync active-high); dif.slave carries start/signed_div/a/b/annul in and
//        stall_div (combinational), ready (one-cycle pulse) and result {HI=rem, LO=quo} out.
module div_ctrl (
  input  logic       clk,
  input  logic       rst,
  div_ctrl_if.slave  dif
);

  typedef enum logic [1:0] {IDLE, BUSY, DIVZERO, DONE} state_t;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q;
  logic [31:0] rem_q;     // partial remainder
  logic [31:0] quo_q;     // dividend bits shift out the top, quotient bits shift in the bottom
  logic [31:0] dvs_q;
  logic        qneg_q, rneg_q;
  logic [63:0] result_q;

  logic        accept;
  logic        b_zero;
  logic [31:0] a_abs, b_abs;
  logic [32:0] shifted, diff;
  logic        qbit;
  logic [31:0] rem_nx, quo_nx, q_fin, r_fin;

  assign accept = (state_q == IDLE) & dif.start & ~dif.annul;
  assign b_zero = (dif.b == 32'd0);
  assign a_abs  = (dif.signed_div & dif.a[31]) ? -dif.a : dif.a;
  assign b_abs  = (dif.signed_div & dif.b[31]) ? -dif.b : dif.b;

  // One restoring step. shifted <= 2*dvs-1, so a non-negative difference always fits
  // in 32 bits and bit 32 is a clean borrow flag.
  assign shifted = {rem_q, quo_q[31]};
  assign diff    = shifted - {1'b0, dvs_q};
  assign qbit    = ~diff[32];
  assign rem_nx  = qbit ? diff[31:0] : shifted[31:0];
  assign quo_nx  = {quo_q[30:0], qbit};
  assign q_fin   = qneg_q ? -quo_nx : quo_nx;
  assign r_fin   = rneg_q ? -rem_nx : rem_nx;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; annul overrides everything and drops back to IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = b_zero ? DIVZERO : BUSY;
      BUSY:    if (cnt_q == 5'd31) state_d = DONE;
      DIVZERO: state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (dif.annul) state_d = IDLE;
  end

  // Outputs
  always_comb begin
    dif.stall_div = ~rst & ~dif.annul &
                    (((state_q == IDLE) & dif.start) | (state_q == BUSY) | (state_q == DIVZERO));
    dif.ready     = (state_q == DONE);
    dif.result    = result_q;
  end

  // Datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= 5'd0;
      rem_q    <= 32'd0;
      quo_q    <= 32'd0;
      dvs_q    <= 32'd0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      result_q <= 64'd0;
    end else if (!dif.annul) begin
      case (state_q)
        IDLE: if (accept) begin
          cnt_q  <= 5'd0;
          rem_q  <= 32'd0;
          // For divide-by-zero keep the raw dividend: it is returned verbatim in HI.
          quo_q  <= b_zero ? dif.a : a_abs;
          dvs_q  <= b_abs;
          qneg_q <= dif.signed_div & (dif.a[31] ^ dif.b[31]);
          rneg_q <= dif.signed_div & dif.a[31];
        end
        BUSY: begin
          rem_q <= rem_nx;
          quo_q <= quo_nx;
          cnt_q <= cnt_q + 5'd1;
          if (cnt_q == 5'd31) result_q <= {r_fin, q_fin};
        end
        DIVZERO: result_q <= {quo_q, 32'hFFFF_FFFF};
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_ctrl.sv
module tb_div_ctrl;

  logic clk;
  logic rst;
  div_ctrl_if dif();

  div_ctrl dut (.clk(clk), .rst(rst), .dif(dif));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic [63:0] sb_q[$];
  logic [63:0] last_res;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", tag, obs, exp);
    end
  endtask

  // Reference: divide on magnitudes, then apply sign rules.
  function automatic logic [63:0] model(input logic [31:0] av, input logic [31:0] bv, input logic sv);
    logic [31:0] ma, mb, q, r;
    if (bv == 32'd0) return {av, 32'hFFFF_FFFF};
    ma = (sv && av[31]) ? (32'd0 - av) : av;
    mb = (sv && bv[31]) ? (32'd0 - bv) : bv;
    q  = ma / mb;
    r  = ma % mb;
    if (sv && (av[31] ^ bv[31])) q = 32'd0 - q;
    if (sv && av[31])            r = 32'd0 - r;
    return {r, q};
  endfunction

  // Called at a negedge with the DUT in IDLE; returns at the negedge of the following IDLE cycle.
  task automatic do_div(input string tag, input logic [31:0] av, input logic [31:0] bv,
                        input logic sv, input logic [63:0] exp);
    int lat;
    bit got;
    logic [63:0] e;
    lat = (bv == 32'd0) ? 2 : 33;
    sb_q.push_back(exp);
    dif.start = 1'b1; dif.signed_div = sv; dif.a = av; dif.b = bv;
    #1;
    got = 0;
    for (int c = 0; c <= lat + 2 && !got; c++) begin
      check({tag, "_stall"}, {63'd0, dif.stall_div}, {63'd0, (c < lat)});
      check({tag, "_ready"}, {63'd0, dif.ready}, {63'd0, (c == lat)});
      if (dif.ready) begin
        got = 1;
        e = sb_q.pop_front();
        check({tag, "_result"}, dif.result, e);
        last_res = e;
        dif.start = 1'b0;   // start still high during DONE was ignored
      end
      @(negedge clk);
    end
    if (!got) begin
      check({tag, "_timeout"}, 64'd0, 64'd1);
      void'(sb_q.pop_front());
    end
    check({tag, "_hold"}, dif.result, last_res);
    check({tag, "_idle_ready"}, {63'd0, dif.ready}, 64'd0);
  endtask

  initial begin
    logic [31:0] ra, rb;
    logic rs;
    rst = 1'b1;
    dif.start = 1'b1; dif.signed_div = 1'b0; dif.a = 32'd5; dif.b = 32'd1; dif.annul = 1'b0;
    last_res = 64'd0;
    repeat (3) @(negedge clk);
    check("rst_stall", {63'd0, dif.stall_div}, 64'd0);
    check("rst_ready", {63'd0, dif.ready}, 64'd0);
    check("rst_result", dif.result, 64'd0);
    dif.start = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    check("idle_stall", {63'd0, dif.stall_div}, 64'd0);

    do_div("u100_7",   32'd100,        32'd7,          1'b0, {32'd2, 32'd14});
    do_div("s-7_2",    32'hFFFF_FFF9,  32'd2,          1'b1, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    do_div("s_ovf",    32'h8000_0000,  32'hFFFF_FFFF,  1'b1, {32'h0000_0000, 32'h8000_0000});
    do_div("u_big",    32'hFFFF_FFFF,  32'h10,         1'b0, {32'hF, 32'h0FFF_FFFF});
    do_div("divzero",  32'h1234_5678,  32'd0,          1'b1, {32'h1234_5678, 32'hFFFF_FFFF});
    do_div("s7_-2",    32'd7,          32'hFFFF_FFFE,  1'b1, {32'd1, 32'hFFFF_FFFD});

    for (int i = 0; i < 4; i++) begin
      ra = $urandom; rb = $urandom >> $urandom_range(0, 28); rs = i[0];
      if (rb == 32'd0) rb = 32'd3;
      do_div("rand", ra, rb, rs, model(ra, rb, rs));
    end

    // Annul in cycle 10 of a divide.
    dif.start = 1'b1; dif.signed_div = 1'b0; dif.a = 32'd1000; dif.b = 32'd3;
    repeat (10) @(negedge clk);
    dif.annul = 1'b1;
    #1;
    check("annul_stall", {63'd0, dif.stall_div}, 64'd0);
    @(negedge clk);
    dif.annul = 1'b0; dif.start = 1'b0;
    #1;
    check("annul_ready", {63'd0, dif.ready}, 64'd0);
    check("annul_result", dif.result, last_res);
    check("annul_idle", {63'd0, dif.stall_div}, 64'd0);
    @(negedge clk);
    do_div("post_annul", 32'd100, 32'd7, 1'b0, {32'd2, 32'd14});

    // Annul together with start in IDLE must not launch a divide.
    dif.start = 1'b1; dif.annul = 1'b1; dif.a = 32'd9; dif.b = 32'd0;
    @(negedge clk);
    dif.start = 1'b0; dif.annul = 1'b0;
    repeat (3) begin
      check("annul_start_ready", {63'd0, dif.ready}, 64'd0);
      @(negedge clk);
    end
    check("annul_start_result", dif.result, last_res);

    // Reset in cycle 15 of a divide; start held throughout.
    dif.start = 1'b1; dif.signed_div = 1'b1; dif.a = 32'hFFFF_FF00; dif.b = 32'd9;
    repeat (15) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_stall", {63'd0, dif.stall_div}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst_result", dif.result, 64'd0);
    check("midrst_ready", {63'd0, dif.ready}, 64'd0);
    check("midrst_accept", {63'd0, dif.stall_div}, 64'd1);
    last_res = 64'd0;
    do_div("post_rst", 32'hFFFF_FF00, 32'd9, 1'b1, model(32'hFFFF_FF00, 32'd9, 1'b1));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/div_ctrl.md
DIV_CTRL -- requirements
Module: div_ctrl

Interface
REQ-001 SHALL have one clock and a reset that is synchronous and active-high.
REQ-002 SHALL have port `clk`: input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port `rst`: input, 1 bit, synchronous active-high reset.
REQ-004 SHALL have port `start`: input, 1 bit, an execute-stage div/divu request; held high by the pipeline while stalled.
REQ-005 SHALL have port `signed_div`: input, 1 bit; 1 = div (signed), 0 = divu (unsigned); sampled with `start`.
REQ-006 SHALL have port `a`: input, 32 bits, the dividend (rs); sampled when the request is accepted.
REQ-007 SHALL have port `b`: input, 32 bits, the divisor (rt); sampled when the request is accepted.
REQ-008 SHALL have port `annul`: input, 1 bit, a flush/exception cancel of the in-flight divide.
REQ-009 SHALL have port `stall_div`: output, 1 bit, a stall request to the hazard unit (drives stallF/D/E).
REQ-010 SHALL have port `ready`: output, 1 bit, a one-cycle pulse indicating that `result` has just been updated.
REQ-011 SHALL have port `result`: output, 64 bits; [63:32] = remainder (HI), [31:0] = quotient (LO).

Function
REQ-012 SHALL implement FSM states IDLE, BUSY, DIVZERO and DONE, with registered state.
REQ-013 IDLE, request accepted: SHALL accept a request when start=1 and annul=0.
- Latch |a| and |b| for signed operation, raw a and b for unsigned.
- Latch sign flags: quotient negative = a[31]^b[31]; remainder negative = a[31]. Both flags are 0 when unsigned.
- Clear the iteration counter.
REQ-014 IDLE, next state: SHALL go to DIVZERO if the latched b==0, else to BUSY.
REQ-015 IDLE, no request: SHALL remain in IDLE.
REQ-016 BUSY: SHALL perform one restoring radix-2 step per cycle (shift the partial remainder left by 1, bring in the next dividend bit, trial-subtract the divisor, set the quotient bit), incrementing the 5-bit counter.
REQ-017 BUSY: SHALL spend exactly 32 cycles in BUSY; the 32nd step (counter==31) SHALL transition to DONE.
REQ-018 BUSY -> DONE: on this transition, `result` SHALL be loaded with the sign-corrected values.
- Quotient negated (two's complement) if the quotient-negative flag is set.
- Remainder negated if the remainder-negative flag is set.
REQ-019 DIVZERO: SHALL last one cycle and then go to DONE, loading result = {a as sampled, 32'hFFFF_FFFF}.
REQ-020 DONE: SHALL assert ready=1 for exactly this one cycle and go to IDLE next cycle; `start` seen in DONE SHALL be ignored.
REQ-021 stall_div SHALL be combinational: ~annul & ((state==IDLE & start) | state==BUSY | state==DIVZERO).
- stall_div SHALL be 0 in DONE, so the stalled instruction advances while `result` is valid.
REQ-022 Latency: start accepted in cycle 0 -> ready in cycle 33, with stall_div high in cycles 0-32.
REQ-023 Latency, divide-by-zero: start accepted in cycle 0 -> ready in cycle 2.
REQ-024 annul=1 in any state SHALL force IDLE on the next edge.
- Result load and ready SHALL be suppressed.
- `result` retains its previous value.
- annul and start together in IDLE SHALL NOT start a divide.
REQ-025 `result` SHALL change only on entry to DONE (or reset) and SHALL hold its value through IDLE until the next completion.
REQ-026 Signed overflow 0x8000_0000 / 0xFFFF_FFFF SHALL yield quotient 0x8000_0000 and remainder 0 (wrap, no trap).
REQ-027 Unsigned operands with bit 31 set SHALL be treated as magnitudes; no sign correction is applied.

Reset
REQ-028 On rst=1 at a rising edge:
- state = IDLE, counter = 0, result = 64'h0, ready = 0, sign flags = 0.
- rst overrides start and annul.
REQ-029 During rst=1, stall_div SHALL be 0 regardless of start.
REQ-030 A reset mid-BUSY SHALL abandon the divide; no ready pulse follows.

Verification
REQ-031 Unsigned 100/7, start in cycle 0 -> stall_div=1 in cycles 0-32, ready in cycle 33, result = {32'd2, 32'd14}.
REQ-032 Signed -7/2 (a=0xFFFF_FFF9, b=2) -> result = {0xFFFF_FFFF, 0xFFFF_FFFD} at cycle 33.
REQ-033 Signed 0x8000_0000 / 0xFFFF_FFFF -> result = {0x0000_0000, 0x8000_0000}; unsigned 0xFFFF_FFFF/0x10 -> {0xF, 0x0FFF_FFFF}.
REQ-034 b=0 with a=0x1234_5678 -> DIVZERO, ready in cycle 2, result = {0x1234_5678, 0xFFFF_FFFF}, stall_div=1 in cycles 0-1.
REQ-035 annul=1 in cycle 10 of a divide -> stall_div=0 in cycle 10, IDLE in cycle 11, no ready, prior result unchanged; a new start in cycle 12 completes in cycle 45.
REQ-036 rst=1 in cycle 15 of a divide -> cycle 16: IDLE, result=0, ready=0; a start held continuously thereafter is accepted in cycle 16.
